palette_pixel_pipe: RTL and testbench
=====================================

PALETTE_PIXEL_PIPE -- requirements
Module: palette_pixel_pipe

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 8, meaning the colour index and palette address width.
REQ-002 The block SHALL have parameter ENTRIES, default 256, meaning the palette depth; legal range 2..2**INDEX_W.
REQ-003 The block SHALL have parameter COLOR_W, default 8, meaning the width of each of red, green and blue.
REQ-004 The block SHALL have port vgaClk, input, 1 bit: the pixel clock, the only clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have ports videoOn, hsync_in and vsync_in, each input, 1 bit: the timing-generator strobes.
REQ-007 The block SHALL have port color_index, input, INDEX_W bits: the palette index of the current pixel.
REQ-008 The block SHALL have ports pal_we (input, 1 bit), pal_addr (input, INDEX_W bits) and pal_wdata (input, 3*COLOR_W bits, ordered {R,G,B}) forming the palette write port.
REQ-009 The block SHALL have ports red, green and blue, each output, COLOR_W bits: the pixel colour.
REQ-010 The block SHALL have ports video_out, hsync_out and vsync_out, each output, 1 bit: the timing strobes, delayed to align with the colour outputs.
REQ-011 The block SHALL have port init_busy, output, 1 bit: high while the palette clear sequence runs.

Function
REQ-012 The block SHALL register all outputs; total latency from inputs to red/green/blue, video_out, hsync_out and vsync_out SHALL be exactly 2 vgaClk cycles.
REQ-013 Stage 1 SHALL register the palette read at color_index together with videoOn, the sync inputs and an in-range flag; stage 2 SHALL register the final colour and the strobes.
REQ-014 The colour outputs SHALL be all-zero when the delayed videoOn is 0, when color_index >= ENTRIES, or when the delayed init_busy is 1; otherwise they SHALL be palette[color_index] split as R=[3C-1:2C], G=[2C-1:C], B=[C-1:0].
REQ-015 When pal_we=1 and init_busy=0, pal_wdata SHALL be written to palette[pal_addr] at the clock edge; a write with pal_addr >= ENTRIES SHALL be dropped.
REQ-016 When a write and a lookup hit the same address in the same cycle, the lookup SHALL return the old value (read-first); the new value SHALL be visible to lookups issued from the next cycle on.
REQ-017 The state machine SHALL have two states, INIT and RUN; reset SHALL force INIT with the clear counter at 0.
REQ-018 In INIT, the block SHALL write zero to palette[counter] and increment the counter once per cycle; after writing entry ENTRIES-1 it SHALL move to RUN, so INIT lasts exactly ENTRIES cycles after reset release.
REQ-019 init_busy SHALL be 1 while in INIT and 0 while in RUN; writes on pal_we during INIT SHALL be ignored.
REQ-020 The sync and video strobes SHALL propagate through the pipeline unchanged in all states.

Reset
REQ-021 While rst=1, all outputs except init_busy SHALL be 0, init_busy SHALL be 1, and the pipeline registers SHALL be cleared.
REQ-022 Palette storage SHALL NOT be reset directly; it SHALL be cleared only by the INIT sequence.
REQ-023 Asserting rst during INIT or RUN SHALL abort any operation and restart INIT from counter 0 once rst is released.

Configuration
REQ-024 When macro PALETTE_RDBK_EN is defined, the block SHALL add an output pal_rdata of 3*COLOR_W bits that returns palette[pal_addr] one cycle after pal_addr is presented, reading 0 for out-of-range addresses and 0 during reset.
REQ-025 When PALETTE_RDBK_EN is undefined, the block SHALL have no pal_rdata port and no second palette read path.

Verification
REQ-026 Release rst, hold pal_we=1 -> init_busy stays high for exactly 256 cycles, and no write lands (all entries read back as 0).
REQ-027 After INIT, write entry 5=24'hFF8000, then drive index 5 with videoOn=1 -> red=FF, green=80, blue=00 exactly 2 cycles later, with hsync_out/vsync_out aligned to the same edge.
REQ-028 Write entry 7=24'h123456 while color_index=7 in the same cycle -> that pixel outputs the old value 000000, and the next pixel outputs 12/34/56.
REQ-029 With ENTRIES=10, drive index 12 with videoOn=1 -> output 000000; drive videoOn=0 with index 5 -> output 000000.
REQ-030 Assert rst for 1 cycle mid-frame with INIT at counter 100 -> outputs go to 0 asynchronously, and INIT restarts and lasts a full 256 cycles.
REQ-031 With PALETTE_RDBK_EN defined, write entry 3=24'hABCDEF and then present pal_addr=3 -> pal_rdata=ABCDEF one cycle later.

Source files
------------

// File: rtl/palette_pixel_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : palette_pixel_pipe                                           |
// | Description : Two-stage palette lookup for a VGA pixel stream. Clears the  |
// |               palette after every reset, then maps colour indices to RGB   |
// |               and keeps the timing strobes aligned with the colour.        |
// |               Optional macro PALETTE_RDBK_EN adds the pal_rdata readback.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module palette_pixel_pipe #(
  parameter int INDEX_W = 8,
  parameter int ENTRIES = 256,
  parameter int COLOR_W = 8
) (
  input  logic                   vgaClk,
  input  logic                   rst,
  input  logic                   videoOn,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic [INDEX_W-1:0]     color_index,
  input  logic                   pal_we,
  input  logic [INDEX_W-1:0]     pal_addr,
  input  logic [3*COLOR_W-1:0]   pal_wdata,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   video_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   init_busy
`ifdef PALETTE_RDBK_EN
  ,
  output logic [3*COLOR_W-1:0]   pal_rdata
`endif
);

  // Address width needed to reach every palette entry.
  localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int PW = 3 * COLOR_W;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_INIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Palette storage; cleared only by the INIT walk, never by reset.
  logic [PW-1:0] palette_mem [ENTRIES];

  logic          w_idx_in_range;
  logic          w_wr_in_range;
  logic [AW-1:0] w_idx_addr;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [PW-1:0] w_mem_wdata;

  // Stage 1: palette word plus strobes and qualifiers.
  logic [PW-1:0] pix1_q, pix1_d;
  logic          video1_q, hs1_q, vs1_q, inrange1_q, busy1_q;
  // Stage 2: final colour and strobes.
  logic [PW-1:0] rgb_q, rgb_d;
  logic          video2_q, hs2_q, vs2_q;

  // Range qualifiers; the low address bits are only used when in range.
  assign w_idx_in_range = (32'(color_index) < ENTRIES);
  assign w_wr_in_range  = (32'(pal_addr) < ENTRIES);
  assign w_idx_addr     = color_index[AW-1:0];

  // Clear-sequence FSM: walk every entry once, then hand over to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == AW'(ENTRIES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state register; reset restarts the clear walk from entry 0.
  always_ff @(posedge vgaClk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy = (state_q == S_INIT);

  // Palette write mux: the clear walk owns the port during INIT.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = pal_addr[AW-1:0];
    w_mem_wdata = pal_wdata;
    if (state_q == S_INIT) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = cnt_q;
      w_mem_wdata = '0;
    end else if (pal_we && w_wr_in_range) begin
      w_mem_we = 1'b1;
    end
  end

  // Palette write; reads elsewhere see the old word in the same cycle.
  always_ff @(posedge vgaClk) begin
    if (w_mem_we) begin
      palette_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Next-state for both pipeline stages; colour is blanked in stage 2.
  always_comb begin
    pix1_d = w_idx_in_range ? palette_mem[w_idx_addr] : '0;
    rgb_d  = (video1_q && inrange1_q && !busy1_q) ? pix1_q : '0;
  end

  // Pipeline registers; strobes pass through regardless of FSM state.
  always_ff @(posedge vgaClk or posedge rst) begin
    if (rst) begin
      pix1_q     <= '0;
      video1_q   <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      inrange1_q <= 1'b0;
      busy1_q    <= 1'b1;
      rgb_q      <= '0;
      video2_q   <= 1'b0;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
    end else begin
      pix1_q     <= pix1_d;
      video1_q   <= videoOn;
      hs1_q      <= hsync_in;
      vs1_q      <= vsync_in;
      inrange1_q <= w_idx_in_range;
      busy1_q    <= init_busy;
      rgb_q      <= rgb_d;
      video2_q   <= video1_q;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
    end
  end

  assign red       = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign green     = rgb_q[2*COLOR_W-1:COLOR_W];
  assign blue      = rgb_q[COLOR_W-1:0];
  assign video_out = video2_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;

`ifdef PALETTE_RDBK_EN
  logic [PW-1:0] rdbk_q, rdbk_d;

  // Host readback: one-cycle registered read, zero when out of range.
  always_comb begin
    rdbk_d = w_wr_in_range ? palette_mem[pal_addr[AW-1:0]] : '0;
  end

  // Readback register.
  always_ff @(posedge vgaClk or posedge rst) begin
    if (rst) begin
      rdbk_q <= '0;
    end else begin
      rdbk_q <= rdbk_d;
    end
  end

  assign pal_rdata = rdbk_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_palette_pixel_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_palette_pixel_pipe                                        |
// | Description : Directed self-checking bench for palette_pixel_pipe; a       |
// |               256-entry instance plus a 10-entry instance on shared        |
// |               stimulus.                                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_palette_pixel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        videoOn, hsync_in, vsync_in;
  logic [7:0]  color_index;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_wdata;

  logic [7:0]  red, green, blue;
  logic        video_out, hsync_out, vsync_out, init_busy;
  logic [7:0]  red10, green10, blue10;
  logic        video_out10, hsync_out10, vsync_out10, init_busy10;
`ifdef PALETTE_RDBK_EN
  logic [23:0] pal_rdata, pal_rdata10;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int n_cyc;

  always #5 clk = ~clk;

  palette_pixel_pipe #(.INDEX_W(8), .ENTRIES(256), .COLOR_W(8)) u_dut (
    .vgaClk(clk), .rst(rst), .videoOn(videoOn), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .color_index(color_index), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .red(red), .green(green),
    .blue(blue), .video_out(video_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .init_busy(init_busy)
`ifdef PALETTE_RDBK_EN
    , .pal_rdata(pal_rdata)
`endif
  );

  palette_pixel_pipe #(.INDEX_W(8), .ENTRIES(10), .COLOR_W(8)) u_dut10 (
    .vgaClk(clk), .rst(rst), .videoOn(videoOn), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .color_index(color_index), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .red(red10), .green(green10),
    .blue(blue10), .video_out(video_out10), .hsync_out(hsync_out10),
    .vsync_out(vsync_out10), .init_busy(init_busy10)
`ifdef PALETTE_RDBK_EN
    , .pal_rdata(pal_rdata10)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until init_busy drops, bounded.
  task automatic count_init(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (init_busy && n < 1000);
  endtask

  task automatic pal_write(input logic [7:0] a, input logic [23:0] d);
    pal_we = 1'b1; pal_addr = a; pal_wdata = d;
    tick();
    pal_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; videoOn = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    color_index = 8'd9; pal_we = 1'b1; pal_addr = 8'd9; pal_wdata = 24'hFFFFFF;
    tick(); tick(); tick();
    // Reset state.
    check("rst_rgb",   {8'h0, red, green, blue}, 32'h0);
    check("rst_hsync", {31'h0, hsync_out}, 32'h0);
    check("rst_video", {31'h0, video_out}, 32'h0);
    check("rst_busy",  {31'h0, init_busy}, 32'h1);

    // INIT length with writes held on; none may land.
    rst = 1'b0;
    count_init(n_cyc);
    pal_we = 1'b0;
    check("init_len", n_cyc, 32'd256);
    check("busy_low", {31'h0, init_busy}, 32'h0);

    // Every entry reads back as zero (including the one hammered during INIT).
    hsync_in = 1'b0; vsync_in = 1'b0;
    for (int i = 0; i < 256; i++) begin
      color_index = 8'(i);
      tick(); tick();
      check("clr_entry", {8'h0, red, green, blue}, 32'h0);
    end

    // Basic lookup and strobe alignment.
    pal_write(8'd5, 24'hFF8000);
    color_index = 8'd5; videoOn = 1'b1; hsync_in = 1'b1; vsync_in = 1'b0;
    tick();
    check("lat1_hsync", {31'h0, hsync_out}, 32'h0);
    tick();
    check("lut5_rgb",   {8'h0, red, green, blue}, 32'hFF8000);
    check("lut5_hsync", {31'h0, hsync_out}, 32'h1);
    check("lut5_vsync", {31'h0, vsync_out}, 32'h0);
    check("lut5_video", {31'h0, video_out}, 32'h1);
    hsync_in = 1'b0; vsync_in = 1'b1;
    tick(); tick();
    check("vs_align", {30'h0, hsync_out, vsync_out}, 32'h1);

    // Read-first collision on entry 7.
    color_index = 8'd7;
    pal_we = 1'b1; pal_addr = 8'd7; pal_wdata = 24'h123456;
    tick();
    pal_we = 1'b0;
    tick();
    check("rf_old", {8'h0, red, green, blue}, 32'h000000);
    tick();
    check("rf_new", {8'h0, red, green, blue}, 32'h123456);

    // Top entry of the full palette.
    pal_write(8'd255, 24'h00FF01);
    color_index = 8'd255;
    tick(); tick();
    check("top_entry", {8'h0, red, green, blue}, 32'h00FF01);

    // Out-of-range index on the 10-entry instance; write to 12 is dropped there.
    pal_write(8'd12, 24'h0ABCDE);
    color_index = 8'd12; videoOn = 1'b1;
    tick(); tick();
    check("idx12_256", {8'h0, red, green, blue}, 32'h0ABCDE);
    check("idx12_10",  {8'h0, red10, green10, blue10}, 32'h0);
    color_index = 8'd5;
    tick(); tick();
    check("idx5_10",   {8'h0, red10, green10, blue10}, 32'hFF8000);
    videoOn = 1'b0;
    tick(); tick();
    check("blank_256", {8'h0, red, green, blue}, 32'h0);
    check("blank_10",  {8'h0, red10, green10, blue10}, 32'h0);
    check("blank_vo",  {31'h0, video_out}, 32'h0);

`ifdef PALETTE_RDBK_EN
    pal_write(8'd3, 24'hABCDEF);
    pal_addr = 8'd3;
    tick();
    check("rdbk3", {8'h0, pal_rdata}, 32'hABCDEF);
    pal_addr = 8'd12;
    tick();
    check("rdbk_oor10", {8'h0, pal_rdata10}, 32'h0);
`endif

    // Asynchronous reset in RUN, then reset again at INIT counter 100.
    videoOn = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; color_index = 8'd5;
    tick(); tick();
    check("pre_rst", {8'h0, red, green, blue}, 32'hFF8000);
    #2 rst = 1'b1;
    #1;
    check("arst_rgb",   {8'h0, red, green, blue}, 32'h0);
    check("arst_hsync", {31'h0, hsync_out}, 32'h0);
    check("arst_busy",  {31'h0, init_busy}, 32'h1);
`ifdef PALETTE_RDBK_EN
    check("arst_rdbk",  {8'h0, pal_rdata}, 32'h0);
`endif
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 3) begin
        check("init_hsync", {31'h0, hsync_out}, 32'h1);
        check("init_rgb",   {8'h0, red, green, blue}, 32'h0);
      end
    end
    check("mid_busy", {31'h0, init_busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_init(n_cyc);
    check("reinit_len", n_cyc, 32'd256);
    tick(); tick();
    check("reinit_clr", {8'h0, red, green, blue}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
